titan_lsu_unit: RTL and testbench

Load/store unit at the MEM stage. It consumes the decoder's `mem_flags` bundle together with the EX-stage address and store data. It runs one Wishbone-style data-port transaction per access. On completion it returns a sign- or zero-extended load result to the MEM/WB path and stalls the pipeline while a transaction is outstanding. Misaligned accesses and bus errors become exception pulses for the CSR/trap logic.

---
 rtl/titan_lsu_unit.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_titan_lsu_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/titan_lsu_unit.sv
// titan_lsu_unit: MEM-stage load/store unit driving a Wishbone-style data port.
// Optional bus-wait timeout is enabled by defining TITAN_LSU_TIMEOUT_EN.
module titan_lsu_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [5:0]  mem_flags,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        kill,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_stall,
    output logic        exc_ld_misalign,
    output logic        exc_st_misalign,
    output logic        exc_ld_fault,
    output logic        exc_st_fault,
    output logic [31:0] exc_badaddr,
    output logic [31:0] dport_address,
    output logic [31:0] dport_data_o,
    output logic [3:0]  dport_sel,
    output logic        dport_we,
    output logic        dport_cyc,
    output logic        dport_stb,
    input  logic [31:0] dport_data_i,
    input  logic        dport_ack,
    input  logic        dport_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic        f_wr, f_rd, f_word, f_hw, f_byte, f_uns;
    logic        size_one, legal, misalign;
    logic [3:0]  sel_new;
    logic [31:0] wdat_new;

    logic [31:0] addr_q, addr_d;
    logic        hw_q, hw_d;
    logic        byte_q, byte_d;
    logic        uns_q, uns_d;
    logic        wr_q, wr_d;
    logic        drop_q, drop_d;

    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;

    logic [31:0] rdata_q, rdata_d;
    logic        ld_mis_q, ld_mis_d;
    logic        st_mis_q, st_mis_d;
    logic        ld_flt_q, ld_flt_d;
    logic        st_flt_q, st_flt_d;
    logic [31:0] badaddr_q, badaddr_d;

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_ext;

`ifdef TITAN_LSU_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    // TIMEOUT must stay within 1..255; the wait counter is 8 bits wide.
    if (TIMEOUT == 0) begin : g_tmo_zero_unsupported
    end

    assign {f_wr, f_rd, f_word, f_hw, f_byte, f_uns} = mem_flags;

    assign size_one = (f_word & ~f_hw & ~f_byte)
                    | (~f_word & f_hw & ~f_byte)
                    | (~f_word & ~f_hw & f_byte);

    assign legal    = mem_valid & (f_wr ^ f_rd) & size_one & ~kill;
    assign misalign = (f_hw & mem_addr[0]) | (f_word & (|mem_addr[1:0]));

    // Byte-lane enables and replicated store data for the incoming request.
    always_comb begin
        sel_new  = 4'b1111;
        wdat_new = mem_wdata;
        if (f_byte) begin
            sel_new  = 4'b0001 << mem_addr[1:0];
            wdat_new = {4{mem_wdata[7:0]}};
        end else if (f_hw) begin
            sel_new  = mem_addr[1] ? 4'b1100 : 4'b0011;
            wdat_new = {2{mem_wdata[15:0]}};
        end
    end

    // Lane select and sign/zero extension of the returned bus word.
    always_comb begin
        lane_b = dport_data_i[7:0];
        unique case (addr_q[1:0])
            2'd0: lane_b = dport_data_i[7:0];
            2'd1: lane_b = dport_data_i[15:8];
            2'd2: lane_b = dport_data_i[23:16];
            2'd3: lane_b = dport_data_i[31:24];
        endcase
        lane_h = addr_q[1] ? dport_data_i[31:16] : dport_data_i[15:0];
        if (byte_q) begin
            ld_ext = {{24{lane_b[7] & ~uns_q}}, lane_b};
        end else if (hw_q) begin
            ld_ext = {{16{lane_h[15] & ~uns_q}}, lane_h};
        end else begin
            ld_ext = dport_data_i;
        end
    end

    // Next-state and register updates for the access sequencer.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        hw_d      = hw_q;
        byte_d    = byte_q;
        uns_d     = uns_q;
        wr_d      = wr_q;
        drop_d    = drop_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rdata_d   = rdata_q;
        ld_mis_d  = ld_mis_q;
        st_mis_d  = st_mis_q;
        ld_flt_d  = ld_flt_q;
        st_flt_d  = st_flt_q;
        badaddr_d = badaddr_q;
`ifdef TITAN_LSU_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                if (legal) begin
                    if (misalign) begin
                        ld_mis_d  = f_rd;
                        st_mis_d  = f_wr;
                        badaddr_d = mem_addr;
                        rdata_d   = 32'h0;
                        state_d   = S_DONE;
                    end else begin
                        addr_d  = mem_addr;
                        hw_d    = f_hw;
                        byte_d  = f_byte;
                        uns_d   = f_uns;
                        wr_d    = f_wr;
                        cyc_d   = 1'b1;
                        we_d    = f_wr;
                        sel_d   = sel_new;
                        adr_d   = {mem_addr[31:2], 2'b00};
                        dat_d   = f_wr ? wdat_new : 32'h0;
`ifdef TITAN_LSU_TIMEOUT_EN
                        cnt_d   = 8'h00;
`endif
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (kill) begin
                    drop_d = 1'b1;
                end
                if (dport_ack) begin
                    rdata_d = wr_q ? 32'h0 : ld_ext;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'h0;
                    adr_d   = 32'h0;
                    dat_d   = 32'h0;
                    state_d = S_DONE;
                end else if (dport_err) begin
                    rdata_d   = 32'h0;
                    ld_flt_d  = ~wr_q;
                    st_flt_d  = wr_q;
                    badaddr_d = addr_q;
                    cyc_d     = 1'b0;
                    we_d      = 1'b0;
                    sel_d     = 4'h0;
                    adr_d     = 32'h0;
                    dat_d     = 32'h0;
                    state_d   = S_DONE;
                end
`ifdef TITAN_LSU_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    rdata_d   = 32'h0;
                    ld_flt_d  = ~wr_q;
                    st_flt_d  = wr_q;
                    badaddr_d = addr_q;
                    cyc_d     = 1'b0;
                    we_d      = 1'b0;
                    sel_d     = 4'h0;
                    adr_d     = 32'h0;
                    dat_d     = 32'h0;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
`endif
            end
            S_DONE: begin
                ld_mis_d = 1'b0;
                st_mis_d = 1'b0;
                ld_flt_d = 1'b0;
                st_flt_d = 1'b0;
                drop_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'h0;
            hw_q      <= 1'b0;
            byte_q    <= 1'b0;
            uns_q     <= 1'b0;
            wr_q      <= 1'b0;
            drop_q    <= 1'b0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'h0;
            adr_q     <= 32'h0;
            dat_q     <= 32'h0;
            rdata_q   <= 32'h0;
            ld_mis_q  <= 1'b0;
            st_mis_q  <= 1'b0;
            ld_flt_q  <= 1'b0;
            st_flt_q  <= 1'b0;
            badaddr_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            hw_q      <= hw_d;
            byte_q    <= byte_d;
            uns_q     <= uns_d;
            wr_q      <= wr_d;
            drop_q    <= drop_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rdata_q   <= rdata_d;
            ld_mis_q  <= ld_mis_d;
            st_mis_q  <= st_mis_d;
            ld_flt_q  <= ld_flt_d;
            st_flt_q  <= st_flt_d;
            badaddr_q <= badaddr_d;
        end
    end

`ifdef TITAN_LSU_TIMEOUT_EN
    // Bus-wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // A dropped or killed access completes silently.
    assign mem_ready       = (state_q == S_DONE) & ~drop_q & ~kill;
    assign mem_stall       = ((state_q == S_IDLE) & legal) | (state_q == S_BUSY);
    assign mem_rdata       = rdata_q;
    assign exc_ld_misalign = ld_mis_q & mem_ready;
    assign exc_st_misalign = st_mis_q & mem_ready;
    assign exc_ld_fault    = ld_flt_q & mem_ready;
    assign exc_st_fault    = st_flt_q & mem_ready;
    assign exc_badaddr     = badaddr_q;

    assign dport_address   = adr_q;
    assign dport_data_o    = dat_q;
    assign dport_sel       = sel_q;
    assign dport_we        = we_q;
    assign dport_cyc       = cyc_q;
    assign dport_stb       = cyc_q;

endmodule

// File: tb/tb_titan_lsu_unit.sv
// Directed testbench for titan_lsu_unit.
// Timeout scenario runs only when TITAN_LSU_TIMEOUT_EN is defined.
module tb_titan_lsu_unit;

`ifdef TITAN_LSU_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [5:0]  mem_flags;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        kill;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_stall;
    logic        exc_ld_misalign;
    logic        exc_st_misalign;
    logic        exc_ld_fault;
    logic        exc_st_fault;
    logic [31:0] exc_badaddr;
    logic [31:0] dport_address;
    logic [31:0] dport_data_o;
    logic [3:0]  dport_sel;
    logic        dport_we;
    logic        dport_cyc;
    logic        dport_stb;
    logic [31:0] dport_data_i;
    logic        dport_ack;
    logic        dport_err;

    int n_tests = 0;
    int n_fail  = 0;

    // {wr, rd, word, hw, byte, unsigned}
    localparam logic [5:0] F_LB  = 6'b010010;
    localparam logic [5:0] F_LBU = 6'b010011;
    localparam logic [5:0] F_LHU = 6'b010101;
    localparam logic [5:0] F_LW  = 6'b011000;
    localparam logic [5:0] F_SH  = 6'b100100;
    localparam logic [5:0] F_SW  = 6'b101000;
    localparam logic [5:0] F_RW  = 6'b111000;
    localparam logic [5:0] F_NOS = 6'b010000;

    titan_lsu_unit #(.TIMEOUT(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_valid       (mem_valid),
        .mem_flags       (mem_flags),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .kill            (kill),
        .mem_rdata       (mem_rdata),
        .mem_ready       (mem_ready),
        .mem_stall       (mem_stall),
        .exc_ld_misalign (exc_ld_misalign),
        .exc_st_misalign (exc_st_misalign),
        .exc_ld_fault    (exc_ld_fault),
        .exc_st_fault    (exc_st_fault),
        .exc_badaddr     (exc_badaddr),
        .dport_address   (dport_address),
        .dport_data_o    (dport_data_o),
        .dport_sel       (dport_sel),
        .dport_we        (dport_we),
        .dport_cyc       (dport_cyc),
        .dport_stb       (dport_stb),
        .dport_data_i    (dport_data_i),
        .dport_ack       (dport_ack),
        .dport_err       (dport_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [5:0] f, input logic [31:0] a, input logic [31:0] w);
        mem_valid = 1'b1;
        mem_flags = f;
        mem_addr  = a;
        mem_wdata = w;
    endtask

    initial begin
        rst          = 1'b1;
        mem_valid    = 1'b0;
        mem_flags    = 6'h0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        kill         = 1'b0;
        dport_data_i = 32'h0;
        dport_ack    = 1'b0;
        dport_err    = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_cyc",   {31'h0, dport_cyc}, 32'h0);
        chk("rst_sel",   {28'h0, dport_sel}, 32'h0);
        chk("rst_adr",   dport_address,      32'h0);
        chk("rst_rdata", mem_rdata,          32'h0);
        chk("rst_ready", {31'h0, mem_ready}, 32'h0);
        chk("rst_stall", {31'h0, mem_stall}, 32'h0);
        rst = 1'b0;
        tick();

        // lb sign-extend
        req(F_LB, 32'h0000_1003, 32'h0);
        #1;
        chk("lb_stall0", {31'h0, mem_stall}, 32'h1);
        chk("lb_cyc0",   {31'h0, dport_cyc}, 32'h0);
        tick();
        chk("lb_cyc",  {31'h0, dport_cyc}, 32'h1);
        chk("lb_stb",  {31'h0, dport_stb}, 32'h1);
        chk("lb_sel",  {28'h0, dport_sel}, 32'h8);
        chk("lb_adr",  dport_address,      32'h0000_1000);
        chk("lb_we",   {31'h0, dport_we},  32'h0);
        chk("lb_do",   dport_data_o,       32'h0);
        chk("lb_rdy0", {31'h0, mem_ready}, 32'h0);
        dport_ack    = 1'b1;
        dport_data_i = 32'h80FF_FF00;
        tick();
        chk("lb_rdy",   {31'h0, mem_ready}, 32'h1);
        chk("lb_rdata", mem_rdata,          32'hFFFF_FF80);
        chk("lb_stall", {31'h0, mem_stall}, 32'h0);
        chk("lb_cyc1",  {31'h0, dport_cyc}, 32'h0);
        dport_ack = 1'b0;
        mem_valid = 1'b0;
        tick();
        chk("lb_rdy1", {31'h0, mem_ready}, 32'h0);

        // lbu zero-extend, then back-to-back lw
        req(F_LBU, 32'h0000_6000, 32'h0);
        tick();
        chk("lbu_sel", {28'h0, dport_sel}, 32'h1);
        dport_ack    = 1'b1;
        dport_data_i = 32'h1234_56F0;
        tick();
        chk("lbu_rdata", mem_rdata, 32'h0000_00F0);
        dport_ack = 1'b0;
        req(F_LW, 32'h0000_7000, 32'h0);
        tick();
        chk("b2b_idle_cyc", {31'h0, dport_cyc}, 32'h0);
        chk("b2b_stall",    {31'h0, mem_stall}, 32'h1);
        tick();
        chk("lw_cyc", {31'h0, dport_cyc}, 32'h1);
        chk("lw_sel", {28'h0, dport_sel}, 32'hF);
        dport_ack    = 1'b1;
        dport_data_i = 32'hCAFE_F00D;
        tick();
        chk("lw_rdy",   {31'h0, mem_ready}, 32'h1);
        chk("lw_rdata", mem_rdata,          32'hCAFE_F00D);
        dport_ack = 1'b0;
        kill      = 1'b1;
        #1;
        chk("done_kill_rdy", {31'h0, mem_ready}, 32'h0);
        kill      = 1'b0;
        mem_valid = 1'b0;
        tick();

        // sh lanes
        req(F_SH, 32'h0000_2002, 32'h1234_ABCD);
        tick();
        chk("sh_sel", {28'h0, dport_sel}, 32'hC);
        chk("sh_do",  dport_data_o,       32'hABCD_ABCD);
        chk("sh_we",  {31'h0, dport_we},  32'h1);
        chk("sh_adr", dport_address,      32'h0000_2000);
        dport_ack = 1'b1;
        tick();
        chk("sh_rdy", {31'h0, mem_ready}, 32'h1);
        chk("sh_exc", {28'h0, exc_ld_misalign, exc_st_misalign,
                       exc_ld_fault, exc_st_fault}, 32'h0);
        dport_ack = 1'b0;
        mem_valid = 1'b0;
        tick();

        // Misaligned load
        req(F_LW, 32'h0000_3001, 32'h0);
        #1;
        chk("mis_stall", {31'h0, mem_stall}, 32'h1);
        tick();
        chk("mis_cyc",  {31'h0, dport_cyc},       32'h0);
        chk("mis_rdy",  {31'h0, mem_ready},       32'h1);
        chk("mis_exc",  {31'h0, exc_ld_misalign}, 32'h1);
        chk("mis_st",   {31'h0, exc_st_misalign}, 32'h0);
        chk("mis_bad",  exc_badaddr,              32'h0000_3001);
        mem_valid = 1'b0;
        tick();
        chk("mis_clr", {31'h0, exc_ld_misalign}, 32'h0);
        chk("mis_rdy1", {31'h0, mem_ready}, 32'h0);

        // Bus error on sw after 3 wait cycles
        req(F_SW, 32'h0000_4000, 32'hDEAD_BEEF);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("err_wait_stall", {31'h0, mem_stall}, 32'h1);
            chk("err_wait_cyc",   {31'h0, dport_cyc}, 32'h1);
            tick();
        end
        chk("err_do", dport_data_o, 32'hDEAD_BEEF);
        dport_err = 1'b1;
        tick();
        chk("err_flt",   {31'h0, exc_st_fault}, 32'h1);
        chk("err_ldf",   {31'h0, exc_ld_fault}, 32'h0);
        chk("err_rdy",   {31'h0, mem_ready},    32'h1);
        chk("err_rdata", mem_rdata,             32'h0);
        chk("err_bad",   exc_badaddr,           32'h0000_4000);
        dport_err = 1'b0;
        mem_valid = 1'b0;
        tick();
        chk("err_idle", {30'h0, mem_ready, exc_st_fault}, 32'h0);

        // Kill mid-BUSY of lhu
        req(F_LHU, 32'h0000_5002, 32'h0);
        tick();
        kill = 1'b1;
        tick();
        chk("kill_cyc", {31'h0, dport_cyc}, 32'h1);
        kill         = 1'b0;
        mem_valid    = 1'b0;
        dport_ack    = 1'b1;
        dport_data_i = 32'h8765_4321;
        tick();
        chk("kill_rdy", {31'h0, mem_ready}, 32'h0);
        chk("kill_exc", {28'h0, exc_ld_misalign, exc_st_misalign,
                         exc_ld_fault, exc_st_fault}, 32'h0);
        chk("kill_cyc1", {31'h0, dport_cyc}, 32'h0);
        dport_ack = 1'b0;
        tick();

        // Illegal requests are ignored
        req(F_RW, 32'h0000_0000, 32'h0);
        #1;
        chk("rw_stall", {31'h0, mem_stall}, 32'h0);
        tick();
        chk("rw_cyc", {30'h0, dport_cyc, mem_ready}, 32'h0);
        req(F_NOS, 32'h0000_0000, 32'h0);
        #1;
        chk("nos_stall", {31'h0, mem_stall}, 32'h0);
        tick();
        chk("nos_cyc", {30'h0, dport_cyc, mem_ready}, 32'h0);
        mem_valid = 1'b0;

        // Reset mid-BUSY
        req(F_LW, 32'h0000_9000, 32'h0);
        tick();
        chk("rb_cyc", {31'h0, dport_cyc}, 32'h1);
        mem_valid = 1'b0;
        rst       = 1'b1;
        tick();
        chk("rb_cyc0", {31'h0, dport_cyc}, 32'h0);
        rst = 1'b0;
        tick();
        chk("rb_rdy", {31'h0, mem_ready}, 32'h0);

`ifdef TITAN_LSU_TIMEOUT_EN
        // Timeout with no termination
        req(F_LW, 32'h0000_8000, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("tmo_cyc", {31'h0, dport_cyc}, 32'h1);
            tick();
        end
        chk("tmo_cyc0",  {31'h0, dport_cyc},    32'h0);
        chk("tmo_flt",   {31'h0, exc_ld_fault}, 32'h1);
        chk("tmo_rdy",   {31'h0, mem_ready},    32'h1);
        chk("tmo_rdata", mem_rdata,             32'h0);
        mem_valid = 1'b0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
